// File: rtl/n_1_mux_pkg.sv
// n_1_mux_pkg: shared limits and select-range helpers for the N-to-1 bit mux.
package n_1_mux_pkg;

    localparam int MUX_N_MAX = 16;

    function automatic int mux_inputs(input int n);
        return 1 << n;
    endfunction

    // sel arrives zero-extended to MUX_N_MAX+1 bits so x = 2**n never overflows
    function automatic logic sel_in_range(input logic [MUX_N_MAX:0] sel, input int x);
        return int'(sel) < x;
    endfunction

endpackage

// File: rtl/n_1_mux_sel.sv
// n_1_mux_sel: combinational bit select with out-of-range detection.
module n_1_mux_sel
    import n_1_mux_pkg::*;
#(
    parameter int n = 2,
    parameter int x = mux_inputs(n)
) (
    input  logic [x-1:0] data_in,
    input  logic [n-1:0] s_line,
    output logic         out_comb,
    output logic         sel_oor
);

    localparam int W = mux_inputs(n);

    logic [W-1:0] data_pad;

    // padding to the full 2**n decode makes out-of-range codes read as 0
    always_comb begin
        data_pad = W'(data_in);
        sel_oor  = !sel_in_range((MUX_N_MAX+1)'(s_line), x);
        out_comb = sel_oor ? 1'b0 : data_pad[s_line];
    end

endmodule

// File: rtl/n_1_mux.sv
// n_1_mux: parameterised N-to-1 single-bit mux with combinational and registered outputs.
module n_1_mux
    import n_1_mux_pkg::*;
#(
    parameter int n = 2,
    parameter int x = mux_inputs(n)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [x-1:0] data_in,
    input  logic [n-1:0] s_line,
    output logic         out,
    output logic         out_comb,
    output logic         sel_err
);

    if (n < 1 || n > MUX_N_MAX) begin : g_bad_n
        $error("n_1_mux: n=%0d outside 1..%0d", n, MUX_N_MAX);
    end
    if (x < 2 || x > mux_inputs(n)) begin : g_bad_x
        $error("n_1_mux: x=%0d outside 2..2**n", x);
    end

    logic out_d, out_q, err_d, err_q;

    n_1_mux_sel #(.n(n), .x(x)) u_sel (
        .data_in  (data_in),
        .s_line   (s_line),
        .out_comb (out_d),
        .sel_oor  (err_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign out_comb = out_d;
    assign out      = out_q;
    assign sel_err  = err_q;

endmodule

// File: tb/tb_n_1_mux.sv
// tb_n_1_mux: directed vector bench for n_1_mux at n=2/x=4 and n=3/x=5.
module tb_n_1_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d0_data;
    logic [1:0] d0_sel;
    logic       d0_out, d0_comb, d0_err;
    logic [4:0] d1_data;
    logic [2:0] d1_sel;
    logic       d1_out, d1_comb, d1_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic       e;
    } vec_t;

    vec_t tv[8];

    always #5 clk = ~clk;

    n_1_mux #(.n(2), .x(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(d0_data), .s_line(d0_sel),
        .out(d0_out), .out_comb(d0_comb), .sel_err(d0_err)
    );

    n_1_mux #(.n(3), .x(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(d1_data), .s_line(d1_sel),
        .out(d1_out), .out_comb(d1_comb), .sel_err(d1_err)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{4'b1010, 2'd0, 1'b0};
        tv[1] = '{4'b1010, 2'd1, 1'b1};
        tv[2] = '{4'b1010, 2'd2, 1'b0};
        tv[3] = '{4'b1010, 2'd3, 1'b1};
        tv[4] = '{4'b1011, 2'd1, 1'b1};
        tv[5] = '{4'b0111, 2'd3, 1'b0};
        tv[6] = '{4'b1000, 2'd3, 1'b1};
        tv[7] = '{4'b1110, 2'd0, 1'b0};

        rst_n   = 1'b0;
        d0_data = 4'b1111;
        d0_sel  = 2'd3;
        d1_data = 5'b11111;
        d1_sel  = 3'd7;
        #1;
        chk("reset_out_pre_clk", d0_out, 1'b0);
        chk("reset_err_pre_clk", d1_err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_out", d0_out, 1'b0);
            chk("reset_err", d0_err, 1'b0);
            chk("reset_comb", d0_comb, 1'b1);
            chk("reset_d1_err", d1_err, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            d0_data = tv[i].d;
            d0_sel  = tv[i].s;
            #1;
            chk($sformatf("vec%0d_comb", i), d0_comb, tv[i].e);
            tick();
            chk($sformatf("vec%0d_out", i), d0_out, tv[i].e);
            chk($sformatf("vec%0d_err", i), d0_err, 1'b0);
        end

        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            logic [3:0] dd;
            logic       e;
            v  = i[5:0];
            dd = v[5:2];
            e  = dd[v[1:0]];
            {d0_data, d0_sel} = v;
            #1;
            chk($sformatf("sweep%0d_comb", i), d0_comb, e);
            tick();
            chk($sformatf("sweep%0d_out", i), d0_out, e);
        end

        d1_data = 5'b11111;
        d1_sel  = 3'd6;
        #1;
        chk("oor6_comb", d1_comb, 1'b0);
        tick();
        chk("oor6_out", d1_out, 1'b0);
        chk("oor6_err", d1_err, 1'b1);
        d1_sel = 3'd4;
        #1;
        chk("in4_comb", d1_comb, 1'b1);
        tick();
        chk("in4_out", d1_out, 1'b1);
        chk("in4_err", d1_err, 1'b0);
        d1_sel = 3'd5;
        tick();
        chk("oor5_err", d1_err, 1'b1);
        chk("oor5_out", d1_out, 1'b0);

        d0_data = 4'b0010;
        d0_sel  = 2'd1;
        tick();
        chk("pre_async_out", d0_out, 1'b1);
        chk("pre_async_d1_err", d1_err, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out", d0_out, 1'b0);
        chk("async_d1_err", d1_err, 1'b0);
        d0_data = 4'b0100;
        d0_sel  = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_hold_out", d0_out, 1'b0);
        tick();
        chk("release_first_edge", d0_out, 1'b1);

        d0_data = 4'bxx1x;
        d0_sel  = 2'd1;
        #1;
        chk("xiso_comb", d0_comb, 1'b1);
        tick();
        chk("xiso_out", d0_out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
